// File: rtl/code_bank_register.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : code_bank_register
//  Description : Multi-slot scrambled passcode bank with a constant-time
//                serial compare engine, per-slot valid flags, slot clearing
//                and registered scrambled readback.
//  Revision    : 1.0 - initial multi-slot release
// ============================================================================
module code_bank_register #(
   parameter int                  DIGITS = 4,
   parameter int                  SLOTS  = 4,
   parameter logic [4*DIGITS-1:0] PERM   = 16'h2103,
   localparam int                 CW     = 4 * DIGITS,
   localparam int                 SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [SW-1:0]    wr_slot,
   input  logic [CW-1:0]    wr_code,
   input  logic             clr_en,
   output logic             wr_ack,
   output logic             wr_err,
   input  logic             cmp_start,
   input  logic [SW-1:0]    cmp_slot,
   input  logic [CW-1:0]    cmp_code,
   output logic             cmp_busy,
   output logic             cmp_done,
   output logic             cmp_match,
   output logic [SLOTS-1:0] slot_valid,
   input  logic [SW-1:0]    rd_slot,
   output logic [CW-1:0]    rd_data
);

   localparam int CNTW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [CW-1:0]   slot_data [SLOTS];
   logic [CW-1:0]   wr_scr;
   logic [CW-1:0]   cmp_scr;
   logic [CW-1:0]   cand;
   logic [SW-1:0]   cur_slot;
   logic [CNTW-1:0] cnt;
   logic            acc;
   logic [3:0]      snap0;

   logic [CW-1:0]   rd_sel;
   logic [CW-1:0]   cmp_sel;
   logic [3:0]      start_sel;
   logic            cmp_valid;

   logic            wr_req;
   logic            wr_in_range;
   logic            wr_hit_busy;
   logic            wr_reject;
   logic            wr_do;
   logic            accept;
   logic            last_digit;
   logic [3:0]      stored_nib;
   logic            nib_eq;

   // Nibble permutation: stored nibble k takes plain nibble PERM field k.
   for (genvar k = 0; k < DIGITS; k++) begin : g_perm
      localparam int SRC = int'(PERM[4*k +: 4]);
      assign wr_scr[4*k +: 4]  = wr_code[4*SRC +: 4];
      assign cmp_scr[4*k +: 4] = cmp_code[4*SRC +: 4];
   end

   assign wr_req      = wr_en | clr_en;
   assign wr_in_range = (int'(wr_slot) < SLOTS);
   assign wr_hit_busy = (state == CMP) && (wr_slot == cur_slot);
   assign wr_reject   = ~wr_in_range | wr_hit_busy;
   assign wr_do       = wr_req & ~wr_reject;

   // Per-slot storage; clear wins over write.
   for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      logic [CW-1:0] data;
      logic          vld;

      // Slot register update on an accepted write or clear addressed here
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data <= '0;
            vld  <= 1'b0;
         end else if (wr_do && (wr_slot == SW'(s))) begin
            if (clr_en) begin
               data <= '0;
               vld  <= 1'b0;
            end else begin
               data <= wr_scr;
               vld  <= 1'b1;
            end
         end
      end

      assign slot_data[s]  = data;
      assign slot_valid[s] = vld;
   end

   // Slot selection for readback, the running compare and compare capture
   always_comb begin
      rd_sel    = '0;
      cmp_sel   = '0;
      start_sel = '0;
      cmp_valid = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
         if (rd_slot == SW'(s)) begin
            rd_sel = slot_data[s];
         end
         if (cur_slot == SW'(s)) begin
            cmp_sel   = slot_data[s];
            cmp_valid = slot_valid[s];
         end
         if (cmp_slot == SW'(s)) begin
            start_sel = slot_data[s][3:0];
         end
      end
   end

   // Write handshake pulses, one cycle after the request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_ack <= wr_req & ~wr_reject;
         wr_err <= wr_req & wr_reject;
      end
   end

   // Registered scrambled readback; out-of-range slots read as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_sel;
      end
   end

   assign accept     = (state == IDLE) && cmp_start;
   assign last_digit = (cnt == CNTW'(DIGITS - 1));
   // Digit 0 uses the value captured at acceptance so a same-edge write
   // cannot influence it; later digits read the live slot.
   assign stored_nib = (cnt == '0) ? snap0 : cmp_sel[{cnt, 2'b00} +: 4];
   assign nib_eq     = (cand[{cnt, 2'b00} +: 4] == stored_nib);

   // Compare FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Compare FSM next state and status outputs
   always_comb begin
      state_nxt = state;
      cmp_busy  = 1'b0;
      cmp_done  = 1'b0;
      case (state)
         IDLE: begin
            if (cmp_start) begin
               state_nxt = CMP;
            end
         end
         CMP: begin
            cmp_busy = 1'b1;
            if (last_digit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            cmp_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Compare datapath: capture, fixed-length nibble walk, result latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand      <= '0;
         cur_slot  <= '0;
         cnt       <= '0;
         acc       <= 1'b0;
         snap0     <= '0;
         cmp_match <= 1'b0;
      end else if (accept) begin
         cand      <= cmp_scr;
         cur_slot  <= cmp_slot;
         cnt       <= '0;
         acc       <= 1'b1;
         snap0     <= start_sel;
         cmp_match <= 1'b0;
      end else if (state == CMP) begin
         cnt <= cnt + CNTW'(1);
         acc <= acc & nib_eq;
         if (last_digit) begin
            cmp_match <= acc & nib_eq & cmp_valid;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_code_bank_register.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_code_bank_register
//  Description : Self-checking bench for code_bank_register (default build
//                plus a 6-digit / 3-slot reversal build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_bank_register;

   localparam int          DIGITS = 4;
   localparam int          SLOTS  = 4;
   localparam int          CW     = 16;
   localparam int          SW     = 2;
   localparam logic [15:0] PERM   = 16'h2103;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // default instance
   logic             wr_en, clr_en, cmp_start;
   logic [SW-1:0]    wr_slot, cmp_slot, rd_slot;
   logic [CW-1:0]    wr_code, cmp_code;
   logic             wr_ack, wr_err, cmp_busy, cmp_done, cmp_match;
   logic [SLOTS-1:0] slot_valid;
   logic [CW-1:0]    rd_data;

   code_bank_register dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_slot(wr_slot), .wr_code(wr_code), .clr_en(clr_en),
      .wr_ack(wr_ack), .wr_err(wr_err),
      .cmp_start(cmp_start), .cmp_slot(cmp_slot), .cmp_code(cmp_code),
      .cmp_busy(cmp_busy), .cmp_done(cmp_done), .cmp_match(cmp_match),
      .slot_valid(slot_valid), .rd_slot(rd_slot), .rd_data(rd_data)
   );

   // 6-digit, 3-slot, nibble-reversal instance
   logic        b_wr_en, b_clr_en, b_cmp_start;
   logic [1:0]  b_wr_slot, b_cmp_slot, b_rd_slot;
   logic [23:0] b_wr_code, b_cmp_code;
   logic        b_wr_ack, b_wr_err, b_cmp_busy, b_cmp_done, b_cmp_match;
   logic [2:0]  b_slot_valid;
   logic [23:0] b_rd_data;

   code_bank_register #(.DIGITS(6), .SLOTS(3), .PERM(24'h012345)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .wr_en(b_wr_en), .wr_slot(b_wr_slot), .wr_code(b_wr_code), .clr_en(b_clr_en),
      .wr_ack(b_wr_ack), .wr_err(b_wr_err),
      .cmp_start(b_cmp_start), .cmp_slot(b_cmp_slot), .cmp_code(b_cmp_code),
      .cmp_busy(b_cmp_busy), .cmp_done(b_cmp_done), .cmp_match(b_cmp_match),
      .slot_valid(b_slot_valid), .rd_slot(b_rd_slot), .rd_data(b_rd_data)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural reference model (default instance) -------
   function automatic logic [CW-1:0] scramble(input logic [CW-1:0] plain);
      logic [CW-1:0] r;
      logic [CW-1:0] p;
      int            src;
      r = '0;
      p = PERM;
      for (int k = 0; k < DIGITS; k++) begin
         src = int'((p >> (4 * k)) & 16'hF);
         r   = r | (((plain >> (4 * src)) & 16'hF) << (4 * k));
      end
      return r;
   endfunction

   logic [CW-1:0]    m_mem [SLOTS];
   logic [SLOTS-1:0] m_valid;
   int               m_left;
   bit               m_done, m_match, m_ack, m_err;
   logic [CW-1:0]    m_cand, m_rd;
   int               m_cslot;
   logic [3:0]       m_pre0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int s = 0; s < SLOTS; s++) m_mem[s] = '0;
            m_valid = '0; m_left = 0; m_done = 0; m_match = 0;
            m_ack = 0; m_err = 0; m_rd = '0; m_cand = '0; m_cslot = 0; m_pre0 = '0;
         end else begin
            bit req, rej;
            req   = wr_en | clr_en;
            rej   = (int'(wr_slot) >= SLOTS) || ((m_left > 0) && (int'(wr_slot) == m_cslot));
            m_ack = req && !rej;
            m_err = req && rej;
            m_rd  = (int'(rd_slot) < SLOTS) ? m_mem[rd_slot] : '0;
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_done  = 1;
                  m_match = (m_cslot < SLOTS) && m_valid[m_cslot] &&
                            (m_cand[3:0] == m_pre0) &&
                            ((m_cand >> 4) == (m_mem[m_cslot] >> 4));
               end
            end else if (m_done) begin
               m_done = 0;
            end else if (cmp_start) begin
               m_cand  = scramble(cmp_code);
               m_cslot = int'(cmp_slot);
               m_pre0  = (m_cslot < SLOTS) ? m_mem[m_cslot][3:0] : 4'h0;
               m_left  = DIGITS;
               m_match = 0;
            end
            if (req && !rej) begin
               if (clr_en) begin
                  m_mem[wr_slot]   = '0;
                  m_valid[wr_slot] = 1'b0;
               end else begin
                  m_mem[wr_slot]   = scramble(wr_code);
                  m_valid[wr_slot] = 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison of the default instance against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("model_wr_ack",     wr_ack,     m_ack);
            chk("model_wr_err",     wr_err,     m_err);
            chk("model_cmp_busy",   cmp_busy,   m_left > 0);
            chk("model_cmp_done",   cmp_done,   m_done);
            chk("model_cmp_match",  cmp_match,  m_match);
            chk("model_slot_valid", slot_valid, m_valid);
            chk("model_rd_data",    rd_data,    m_rd);
         end
      end
   end

   // mid_mode: 0 none, 1 write during compare, 2 second cmp_start during compare
   task automatic do_cmp(input string nm, input logic [1:0] slot, input logic [15:0] code,
                         input bit exp_match, input int mid_mode, input logic [1:0] mslot,
                         input logic [15:0] mcode, input bit mexp_err);
      int lat;
      int nbusy;
      lat = 0;
      nbusy = 0;
      cmp_slot = slot; cmp_code = code; cmp_start = 1'b1;
      tick();
      cmp_start = 1'b0; wr_en = 1'b0; clr_en = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 3 && mid_mode == 1) begin
            chk({nm, "_mid_err"}, wr_err, mexp_err);
            chk({nm, "_mid_ack"}, wr_ack, !mexp_err);
         end
         if (cmp_done) begin
            lat = i;
            break;
         end
         if (cmp_busy) nbusy++;
         @(posedge clk);
         #2;
         if (i == 1 && mid_mode == 1) begin
            wr_en = 1'b1; wr_slot = mslot; wr_code = mcode;
         end
         if (i == 1 && mid_mode == 2) cmp_start = 1'b1;
         if (i == 2) begin
            wr_en = 1'b0; cmp_start = 1'b0;
         end
      end
      chk({nm, "_latency"}, lat, 5);
      chk({nm, "_busy_cycles"}, nbusy, 4);
      chk({nm, "_match"}, cmp_match, exp_match);
   endtask

   task automatic b_cmp(input string nm, input logic [1:0] slot, input logic [23:0] code,
                        input bit exp_match);
      int lat;
      lat = 0;
      b_cmp_slot = slot; b_cmp_code = code; b_cmp_start = 1'b1;
      tick();
      b_cmp_start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (b_cmp_done) begin
            lat = i;
            break;
         end
         @(posedge clk);
         #2;
      end
      chk({nm, "_latency"}, lat, 7);
      chk({nm, "_match"}, b_cmp_match, exp_match);
      tick();
   endtask

   task automatic count_no_done(input string nm, input int n);
      int nd;
      nd = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cmp_done) nd++;
         tick();
      end
      chk(nm, nd, 0);
   endtask

   logic [15:0] pool [4];

   initial begin
      pool[0] = 16'h1234; pool[1] = 16'h9876; pool[2] = 16'h0000; pool[3] = 16'hBEEF;
      wr_en = 0; clr_en = 0; cmp_start = 0; wr_slot = 0; cmp_slot = 0; rd_slot = 0;
      wr_code = 0; cmp_code = 0;
      b_wr_en = 0; b_clr_en = 0; b_cmp_start = 0; b_wr_slot = 0; b_cmp_slot = 0;
      b_rd_slot = 0; b_wr_code = 0; b_cmp_code = 0;
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_slot_valid", slot_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", cmp_busy, 0);
      chk("rst_done", cmp_done, 0);
      chk("rst_match", cmp_match, 0);
      chk("rst_ack_err", {wr_ack, wr_err}, 0);
      tick();
      rst_n = 1;

      // write slot0 = 1234, stored as 2341
      wr_en = 1; wr_slot = 0; wr_code = 16'h1234;
      tick();
      wr_en = 0; rd_slot = 0;
      @(negedge clk);
      chk("wr0_ack", wr_ack, 1);
      chk("wr0_err", wr_err, 0);
      chk("wr0_valid", slot_valid, 4'b0001);
      tick();
      @(negedge clk);
      chk("wr0_rd", rd_data, 16'h2341);
      tick();

      do_cmp("cmp_hit", 0, 16'h1234, 1, 0, 0, 0, 0);            tick();
      do_cmp("cmp_miss", 0, 16'h1235, 0, 0, 0, 0, 0);           tick();
      do_cmp("cmp_unwritten", 2, 16'h0000, 0, 0, 0, 0, 0);      tick();
      do_cmp("cmp_wr_same", 0, 16'h1234, 1, 1, 0, 16'hAAAA, 1); tick();
      do_cmp("cmp_wr_other", 0, 16'h1234, 1, 1, 1, 16'h9876, 0);
      tick();
      rd_slot = 1;
      tick();
      @(negedge clk);
      chk("rd_slot1", rd_data, 16'h8769);  // 9876 through PERM 2103
      tick();

      // write accepted on the same edge as the compare: digit 0 sees the old 1
      wr_en = 1; wr_slot = 0; wr_code = 16'h5234;
      do_cmp("cmp_same_edge_wr", 0, 16'h5234, 0, 0, 0, 0, 0); tick();
      do_cmp("cmp_after_wr", 0, 16'h5234, 1, 0, 0, 0, 0);     tick();

      // clear with wr_en and clr_en together
      wr_en = 1; clr_en = 1; wr_slot = 0; wr_code = 16'h1234;
      tick();
      wr_en = 0; clr_en = 0; rd_slot = 0;
      @(negedge clk);
      chk("clr_ack", wr_ack, 1);
      chk("clr_valid", slot_valid, 4'b0010);
      tick();
      @(negedge clk);
      chk("clr_rd", rd_data, 0);
      tick();
      do_cmp("cmp_cleared", 0, 16'h2345, 0, 2, 0, 0, 0);
      tick();
      count_no_done("single_done", 6);

      // reset in the middle of a compare
      rd_slot = 1; cmp_slot = 1; cmp_code = 16'h9876; cmp_start = 1;
      tick();
      cmp_start = 0;
      tick();
      @(negedge clk);
      chk("pre_rst_busy", cmp_busy, 1);
      tick();
      rst_n = 0;
      #1;
      chk("midrst_busy", cmp_busy, 0);
      chk("midrst_done", cmp_done, 0);
      chk("midrst_match", cmp_match, 0);
      chk("midrst_valid", slot_valid, 0);
      chk("midrst_rd", rd_data, 0);
      chk("midrst_ack_err", {wr_ack, wr_err}, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1;
      count_no_done("rst_no_done", 8);

      // 6-digit reversal build
      b_wr_en = 1; b_wr_slot = 0; b_wr_code = 24'h123456;
      tick();
      b_wr_en = 0; b_rd_slot = 0;
      @(negedge clk);
      chk("b_wr_ack", b_wr_ack, 1);
      tick();
      @(negedge clk);
      chk("b_rd", b_rd_data, 24'h654321);
      tick();
      b_cmp("b_hit", 0, 24'h123456, 1);
      b_cmp("b_miss", 0, 24'h123457, 0);
      b_cmp("b_oor", 3, 24'h123456, 0);
      b_wr_en = 1; b_wr_slot = 3; b_wr_code = 24'h111111;
      tick();
      b_wr_en = 0; b_rd_slot = 3;
      @(negedge clk);
      chk("b_oor_wr_err", b_wr_err, 1);
      chk("b_oor_wr_ack", b_wr_ack, 0);
      chk("b_oor_valid", b_slot_valid, 3'b001);
      tick();
      @(negedge clk);
      chk("b_oor_rd", b_rd_data, 0);
      tick();

      // randomized traffic on the default build
      for (int c = 0; c < 4000; c++) begin
         wr_en     = ($urandom_range(0, 3) == 0);
         clr_en    = ($urandom_range(0, 11) == 0);
         wr_slot   = 2'($urandom_range(0, 3));
         wr_code   = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
         cmp_start = ($urandom_range(0, 2) == 0);
         cmp_slot  = 2'($urandom_range(0, 3));
         cmp_code  = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
         rd_slot   = 2'($urandom_range(0, 3));
         if (c == 2000) rst_n = 0;
         if (c == 2001) rst_n = 1;
         tick();
      end
      wr_en = 0; clr_en = 0; cmp_start = 0;
      repeat (8) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
